// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC and
// FSM state encodings.
package ifu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_REQ  = 2'd0;  // issuing a request for fetch_pc
    localparam state_t ST_WAIT = 2'd1;  // granted, awaiting the response
    localparam state_t ST_HOLD = 2'd2;  // instruction buffered for the core
    localparam state_t ST_DROP = 2'd3;  // flushing a stale response

    function automatic logic is_aligned(input logic [XLEN-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, runs one-outstanding req/gnt/rvalid
// fetches and holds the returned word for the core until it is consumed.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              imem_err_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              inst_err_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i
);

    state_t              state_q,    state_d;
    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0]   inst_q,     inst_d;
    logic [XLEN-1:0]     inst_pc_q,  inst_pc_d;
    logic                inst_err_q, inst_err_d;

    logic pc_aligned;
    logic granted;

    assign pc_aligned = is_aligned(fetch_pc_q);

    // A misaligned PC never reaches memory; it is reported as a fetch fault instead.
    assign imem_req_o  = !rst && (state_q == ST_REQ) && pc_aligned;
    assign imem_addr_o = rst ? RESET_PC : fetch_pc_q;
    assign granted     = imem_req_o && imem_gnt_i;

    assign inst_valid_o = (state_q == ST_HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_err_o   = inst_err_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;

        case (state_q)
            ST_REQ: begin
                if (redirect_i) begin
                    state_d = granted ? ST_DROP : ST_REQ;
                end else if (!pc_aligned) begin
                    state_d    = ST_HOLD;
                    inst_d     = '0;
                    inst_pc_d  = fetch_pc_q;
                    inst_err_d = 1'b1;
                end else if (granted) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_HOLD;
                        inst_d     = imem_err_i ? '0 : imem_rdata_i;
                        inst_pc_d  = fetch_pc_q;
                        inst_err_d = imem_err_i;
                    end
                end else if (redirect_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect_i || inst_ready_i) begin
                    state_d = ST_REQ;
                end
                if (!redirect_i && inst_ready_i) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
            end
            ST_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A redirect always overrides the sequential next PC.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= RESET_PC;
            inst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
        end
    end

endmodule
